// File: rtl/or_16_if.sv
// Operand/result bundle for or_16: operands in with valid/ready, registered result out.
// Optional popcnt_o exists only when OR16_POPCOUNT_EN is defined.
interface or_16_if #(
    parameter int WIDTH = 16
) ();
    localparam int PW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] out_o;
    logic             zero_o;
    logic             ones_o;
    logic             valid_o;
    logic             ready_i;
`ifdef OR16_POPCOUNT_EN
    logic [PW-1:0]    popcnt_o;
`endif

    modport slave (
`ifdef OR16_POPCOUNT_EN
        output popcnt_o,
`endif
        input  a_i, b_i, valid_i, ready_i,
        output ready_o, out_o, zero_o, ones_o, valid_o
    );

    modport master (
`ifdef OR16_POPCOUNT_EN
        input  popcnt_o,
`endif
        output a_i, b_i, valid_i, ready_i,
        input  ready_o, out_o, zero_o, ones_o, valid_o
    );
endinterface

// File: rtl/or_16.sv
// Purpose: registered bitwise OR of two WIDTH-bit operands with zero/all-ones flags (OR16_POPCOUNT_EN adds popcnt_o).
// Latency: 1 cycle from accept to valid_o; full throughput while ready_i is high.
// Backpressure: one-entry output stage, ready_o = !valid_o || ready_i; a stalled result holds.
module or_16 #(
    parameter int WIDTH = 16
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    or_16_if.slave bus
);
    localparam int PW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] res;
    logic             accept;
    logic [WIDTH-1:0] out_d,   out_q;
    logic             zero_d,  zero_q;
    logic             ones_d,  ones_q;
    logic             valid_d, valid_q;
`ifdef OR16_POPCOUNT_EN
    logic [PW-1:0]    popcnt_d, popcnt_q;
    logic [PW-1:0]    res_cnt;
`endif

    assign res         = bus.a_i | bus.b_i;
    assign bus.ready_o = !valid_q || bus.ready_i;
    assign accept      = bus.valid_i && bus.ready_o;

`ifdef OR16_POPCOUNT_EN
    always_comb begin
        res_cnt = '0;
        for (int k = 0; k < WIDTH; k++) begin
            res_cnt = res_cnt + PW'(res[k]);
        end
    end
`endif

    // Operands are only looked at on accept, so X on an idle bus never reaches a flop.
    always_comb begin
        out_d   = out_q;
        zero_d  = zero_q;
        ones_d  = ones_q;
        valid_d = valid_q;
`ifdef OR16_POPCOUNT_EN
        popcnt_d = popcnt_q;
`endif
        if (accept) begin
            out_d   = res;
            zero_d  = ~|res;
            ones_d  = &res;
            valid_d = 1'b1;
`ifdef OR16_POPCOUNT_EN
            popcnt_d = res_cnt;
`endif
        end else if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q   <= '0;
            zero_q  <= 1'b1;
            ones_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef OR16_POPCOUNT_EN
            popcnt_q <= '0;
`endif
        end else begin
            out_q   <= out_d;
            zero_q  <= zero_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
`ifdef OR16_POPCOUNT_EN
            popcnt_q <= popcnt_d;
`endif
        end
    end

    assign bus.out_o   = out_q;
    assign bus.zero_o  = zero_q;
    assign bus.ones_o  = ones_q;
    assign bus.valid_o = valid_q;
`ifdef OR16_POPCOUNT_EN
    assign bus.popcnt_o = popcnt_q;
`endif
endmodule

// File: tb/tb_or_16.sv
// Randomized and directed bench for or_16 against a queue-based reference of the output stage.
module tb_or_16;
    localparam int WIDTH = 16;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    or_16_if #(.WIDTH(WIDTH)) bus ();

    or_16 #(.WIDTH(WIDTH)) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_out = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(bus.valid_o), 32'(exp_q.size() != 0));
        chk({tag, ".out"},   32'(bus.out_o),   32'(last_out));
        chk({tag, ".zero"},  32'(bus.zero_o),  32'(last_out == '0));
        chk({tag, ".ones"},  32'(bus.ones_o),  32'(last_out == {WIDTH{1'b1}}));
`ifdef OR16_POPCOUNT_EN
        chk({tag, ".popcnt"}, 32'(bus.popcnt_o), 32'($countones(last_out)));
`endif
    endtask

    // Called just after an active edge: drive, check ready, clock, update model, check outputs.
    task automatic step(input string tag, input logic vld, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic rdy);
        logic space, acc, pop;
        bus.valid_i = vld;
        bus.a_i     = vld ? a : 'x;
        bus.b_i     = vld ? b : 'x;
        bus.ready_i = rdy;
        #1;
        space = (exp_q.size() == 0) || rdy;
        chk({tag, ".ready_o"}, 32'(bus.ready_o), 32'(space));
        acc = vld && space;
        pop = (exp_q.size() != 0) && rdy;
        @(posedge clk_i);
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(a | b);
            last_out = a | b;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_out = '0;
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs("reset");
        rst_ni = 1'b1;

        step("zero",   1'b1, 16'h0000, 16'h0000, 1'b1);
        chk("zero.flag", 32'(bus.zero_o), 32'd1);
        step("a_ones", 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        chk("a_ones.flag", 32'(bus.ones_o), 32'd1);
        step("b_ones", 1'b1, 16'h0000, 16'hFFFF, 1'b1);
        step("ab_one", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        step("mixed",  1'b1, 16'hAAAA, 16'h3BF1, 1'b1);
        chk("mixed.value", 32'(bus.out_o), 32'h0000BBFB);
`ifdef OR16_POPCOUNT_EN
        chk("mixed.pop13", 32'(bus.popcnt_o), 32'd13);
`endif
        step("drain", 1'b0, '0, '0, 1'b1);

        for (int i = 0; i < 5; i++) begin
            step("b2b", 1'b1, 16'(1 << i), 16'(16'h0100 << i), 1'b1);
        end
        step("b2b_drain", 1'b0, '0, '0, 1'b1);

        step("load",  1'b1, 16'h1234, 16'h0001, 1'b0);
        step("stall", 1'b1, 16'h5555, 16'h0000, 1'b0);
        step("stall", 1'b1, 16'h00F0, 16'h0F00, 1'b0);
        chk("stall.held", 32'(bus.out_o), 32'h00001235);
        step("release", 1'b1, 16'h00F0, 16'h0F00, 1'b1);
        chk("release.value", 32'(bus.out_o), 32'h00000FF0);

        step("preload", 1'b1, 16'hC3C3, 16'h0000, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        chk("async_rst.valid", 32'(bus.valid_o), 32'd0);
        chk("async_rst.out",   32'(bus.out_o),   32'd0);
        chk("async_rst.zero",  32'(bus.zero_o),  32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        check_outputs("post_rst");

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 40; i++) begin
            step("rand_sparse", 1'b1, 16'($urandom) & 16'($urandom), 16'($urandom) & 16'($urandom),
                 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
